ram_arbiter: RTL

- Memory-side stage between the two cores' caches (icache/dcache per core) and the single RAM port.
- Chooses one cache request per transaction, drives the RAM request lines, and returns load data plus wait/done status to the requester.
- Its RAM-side outputs feed the testbench-control mux that sits in front of RAM.
- Arbitration is round-robin between cores and fixed priority within a core.

---
 rtl/cpu_types_pkg.sv | 32 +++
 rtl/ram_arbiter_if.sv | 37 +++
 rtl/ram_arbiter_rr_pick.sv | 32 +++
 rtl/ram_arbiter.sv | 101 ++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM status, words, and the arbiter's registered grant.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        SRC_I  = 2'd0,
        SRC_DR = 2'd1,
        SRC_DW = 2'd2
    } src_t;

    typedef struct packed {
        logic  core;
        src_t  src;
        word_t addr;
        word_t store;
    } grant_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StXfer = 2'd1,
        StDone = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Cache-side request/response bundle plus the single RAM port seen by ram_arbiter.
interface ram_arbiter_if #(
    parameter int NCORES = 2,
    parameter int WORD_W = 32
) ();

    logic [NCORES-1:0]             iREN;
    logic [NCORES-1:0]             dREN;
    logic [NCORES-1:0]             dWEN;
    logic [NCORES-1:0][WORD_W-1:0] iaddr;
    logic [NCORES-1:0][WORD_W-1:0] daddr;
    logic [NCORES-1:0][WORD_W-1:0] dstore;
    logic [NCORES-1:0]             iwait;
    logic [NCORES-1:0]             dwait;
    logic [NCORES-1:0][WORD_W-1:0] iload;
    logic [NCORES-1:0][WORD_W-1:0] dload;

    logic                          ramREN;
    logic                          ramWEN;
    logic [WORD_W-1:0]             ramaddr;
    logic [WORD_W-1:0]             ramstore;
    logic [WORD_W-1:0]             ramload;
    cpu_types_pkg::ramstate_t      ramstate;

    // Arbiter view.
    modport slave (
        input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    // Caches + RAM view.
    modport master (
        output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational winner select: round-robin across cores, dWEN > dREN > iREN within a core.
module rr_pick
    import cpu_types_pkg::*;
#(
    parameter int NCORES = 2
) (
    input  logic [NCORES-1:0] iren,
    input  logic [NCORES-1:0] dren,
    input  logic [NCORES-1:0] dwen,
    input  logic              rr_ptr,
    output logic              valid,
    output logic              core,
    output src_t              src
);

    logic [NCORES-1:0] req;

    assign req   = iren | dren | dwen;
    assign valid = |req;
    // Favoured core wins if it asks; otherwise the other one.
    assign core  = req[rr_ptr] ? rr_ptr : ~rr_ptr;

    always_comb begin
        src = SRC_I;
        if (dwen[core]) begin
            src = SRC_DW;
        end else if (dren[core]) begin
            src = SRC_DR;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Memory-side arbiter: grants one cache request at a time onto the single RAM port.
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NCORES  = 2,
    parameter int WORD_W  = 32,
    parameter int RR_INIT = 0
) (
    input  logic         CLK,
    input  logic         RST,
    ram_arbiter_if.slave bus
);

    arb_state_t        state_q, state_d;
    logic              rr_ptr_q;
    grant_t            grant_q, grant_d;
    logic              pick_valid;
    logic              pick_core;
    src_t              pick_src;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_store;

    rr_pick #(
        .NCORES(NCORES)
    ) u_rr_pick (
        .iren  (bus.iREN),
        .dren  (bus.dREN),
        .dwen  (bus.dWEN),
        .rr_ptr(rr_ptr_q),
        .valid (pick_valid),
        .core  (pick_core),
        .src   (pick_src)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= StIdle;
            rr_ptr_q <= 1'(RR_INIT);
            grant_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && pick_valid) begin
                grant_q  <= grant_d;
                // winner + 1 mod 2
                rr_ptr_q <= ~pick_core;
            end
        end
    end

    always_comb begin
        req_addr  = (pick_src == SRC_I) ? bus.iaddr[pick_core] : bus.daddr[pick_core];
        req_store = (pick_src == SRC_DW) ? bus.dstore[pick_core] : '0;

        grant_d.core  = pick_core;
        grant_d.src   = pick_src;
        grant_d.addr  = req_addr;
        grant_d.store = req_store;

        state_d      = state_q;
        bus.iwait    = '1;
        bus.dwait    = '1;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StXfer;
                end
            end
            StXfer: begin
                // ERROR keeps the lines up so RAM retries the same access.
                bus.ramREN   = (grant_q.src != SRC_DW);
                bus.ramWEN   = (grant_q.src == SRC_DW);
                bus.ramaddr  = grant_q.addr;
                bus.ramstore = grant_q.store;
                if (bus.ramstate == ACCESS) begin
                    state_d = StDone;
                    if (grant_q.src == SRC_I) begin
                        bus.iwait[grant_q.core] = 1'b0;
                        bus.iload[grant_q.core] = bus.ramload;
                    end else begin
                        bus.dwait[grant_q.core] = 1'b0;
                        bus.dload[grant_q.core] = bus.ramload;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule
